// File: rtl/tff_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tff_counter_arbiter
//
// Round-robin arbiter and sequencer that owns a single T-flip-flop up/down
// counter. One requester is granted at a time; its 2-bit op is turned into a
// per-bit toggle vector and committed on one clock edge. The transaction is
// then acknowledged with a one-cycle done pulse.
//
// Handshake: req[i] is level-sensitive and is sampled only in IDLE. Once gnt[i]
// rises the operation is committed; dropping req[i] afterwards does not cancel
// it. op[2i+1:2i] must be stable from gnt[i] rising until done rises. done is
// high for exactly one cycle, and count already holds the new value while it
// is high.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        per-requester request (N_REQ bits)
//   op         per-requester op, 2 bits each: 00 hold, 01 inc, 10 dec, 11 clear
//   gnt        registered one-hot grant
//   done       one-cycle acknowledge
//   wrap       one-cycle pulse with done on inc from all-ones or dec from zero
//   busy       high whenever the FSM is not in IDLE
//   count      counter value (T flip-flops)
//   dbg_state  FSM state encoding: 0 IDLE, 1 EXEC, 2 ACK
// -----------------------------------------------------------------------------
module tff_counter_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   op,
  output logic [N_REQ-1:0]     gnt,
  output logic                 done,
  output logic                 wrap,
  output logic                 busy,
  output logic [WIDTH-1:0]     count,
  output logic [1:0]           dbg_state
);

  localparam int LW = $clog2(N_REQ);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state;
  logic [LW-1:0]     last;

  logic              any_req;
  logic [LW-1:0]     win_idx;
  logic [N_REQ-1:0]  win_oh;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  t;
  logic              wrap_next;
  logic              carry;

  // Round-robin search starting at last+1: first scan indices above the
  // pointer, then wrap around to indices at or below it.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_req && req[i] && (i > int'(last))) begin
        any_req   = 1'b1;
        win_idx   = LW'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any_req && req[i] && (i <= int'(last))) begin
        any_req   = 1'b1;
        win_idx   = LW'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  // The registered one-hot grant selects the op field of the owner.
  always_comb begin
    sel_op = OP_HOLD;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) sel_op = op[2*i +: 2];
    end
  end

  // Toggle vector: bit i toggles when all lower bits are 1 (inc) or all are
  // 0 (dec). The running carry is that prefix AND.
  always_comb begin
    t         = '0;
    wrap_next = 1'b0;
    carry     = 1'b1;
    case (sel_op)
      OP_INC: begin
        for (int i = 0; i < WIDTH; i++) begin
          t[i]  = carry;
          carry = carry & count[i];
        end
        wrap_next = &count;
      end
      OP_DEC: begin
        for (int i = 0; i < WIDTH; i++) begin
          t[i]  = carry;
          carry = carry & ~count[i];
        end
        wrap_next = ~|count;
      end
      OP_CLR:  t = count;
      default: t = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= LW'(N_REQ - 1);
      gnt   <= '0;
      done  <= 1'b0;
      wrap  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          wrap <= 1'b0;
          if (any_req) begin
            gnt   <= win_oh;
            last  <= win_idx;
            state <= EXEC;
          end else begin
            gnt <= '0;
          end
        end
        EXEC: begin
          count <= count ^ t;
          done  <= 1'b1;
          wrap  <= wrap_next;
          state <= ACK;
        end
        ACK: begin
          done  <= 1'b0;
          wrap  <= 1'b0;
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          wrap  <= 1'b0;
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
